// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out stream bundle for the byte-to-word packer.
// The slave modport is the packer side. The master modport is the source/sink environment.
interface byte_word_packer_if #(
   parameter int BYTES = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [7:0]           in_data;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [8*BYTES-1:0]   out_data;
   logic [BYTES-1:0]     out_keep;
   logic                 out_last;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );
endinterface

// File: rtl/byte_word_packer.sv
// Packs a valid/ready byte stream into BYTES-wide words, with selectable lane order.
// Short packet tails are zero-padded and marked through out_keep and out_last.
module byte_word_packer #(
   parameter int BYTES      = 4,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   byte_word_packer_if.slave   bus
);
   localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [8*BYTES-1:0] acc_q, acc_d;
   logic [BYTES-1:0]   keep_acc_q, keep_acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [8*BYTES-1:0] out_data_q, out_data_d;
   logic [BYTES-1:0]   out_keep_q, out_keep_d;
   logic               out_last_q, out_last_d;
   logic               out_valid_q, out_valid_d;

   logic               in_ready;
   logic               accept;
   logic               complete;
   logic [BYTES-1:0]   lane_hit;
   logic [8*BYTES-1:0] merged_data;
   logic [BYTES-1:0]   merged_keep;

   assign in_ready = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;
   assign complete = (cnt_q == CW'(BYTES - 1)) || bus.in_last;

   // Each lane knows which byte position feeds it, so the merge is a one-hot select.
   generate
      for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
         localparam int BYTE_IDX = BIG_ENDIAN ? (BYTES - 1 - gi) : gi;
         assign lane_hit[gi]          = (cnt_q == CW'(BYTE_IDX));
         assign merged_data[8*gi +: 8] = lane_hit[gi] ? bus.in_data : acc_q[8*gi +: 8];
      end
   endgenerate

   assign merged_keep = keep_acc_q | lane_hit;

   always_comb begin
      acc_d       = acc_q;
      keep_acc_d  = keep_acc_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;

      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (complete) begin
            out_data_d  = merged_data;
            out_keep_d  = merged_keep;
            out_last_d  = bus.in_last;
            out_valid_d = 1'b1;
            acc_d       = '0;
            keep_acc_d  = '0;
            cnt_d       = '0;
         end else begin
            acc_d      = merged_data;
            keep_acc_d = merged_keep;
            cnt_d      = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         keep_acc_q  <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         keep_acc_q  <= keep_acc_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_keep  = out_keep_q;
   assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_byte_word_packer.sv
// Drives identical byte streams into big- and little-endian packers.
// A reference model predicts each word, and the predicted words are compared as the outputs are consumed.
module tb_byte_word_packer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int valid_cycles = 0;
   int stall_cnt = 0;

   logic [36:0] q_be[$];
   logic [36:0] q_le[$];
   logic [7:0]  cur[$];
   int          hs_cyc[$];

   byte_word_packer_if #(.BYTES(4)) if_be ();
   byte_word_packer_if #(.BYTES(4)) if_le ();

   assign if_be.in_valid  = in_valid;
   assign if_be.in_data   = in_data;
   assign if_be.in_last   = in_last;
   assign if_be.out_ready = out_ready;
   assign if_le.in_valid  = in_valid;
   assign if_le.in_data   = in_data;
   assign if_le.in_last   = in_last;
   assign if_le.out_ready = out_ready;

   byte_word_packer #(.BYTES(4), .BIG_ENDIAN(1'b1)) u_be (.clk(clk), .rst(rst), .bus(if_be.slave));
   byte_word_packer #(.BYTES(4), .BIG_ENDIAN(1'b0)) u_le (.clk(clk), .rst(rst), .bus(if_le.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: collect accepted bytes and emit both lane orders when a word closes.
   task automatic model_accept(input logic [7:0] d, input logic last);
      logic [31:0] be_w, le_w;
      logic [3:0]  be_k, le_k;
      cur.push_back(d);
      if (last || cur.size() == 4) begin
         be_w = '0; le_w = '0; be_k = '0; le_k = '0;
         for (int i = 0; i < cur.size(); i++) begin
            be_w[8*(3-i) +: 8] = cur[i];
            be_k[3-i]          = 1'b1;
            le_w[8*i +: 8]     = cur[i];
            le_k[i]            = 1'b1;
         end
         q_be.push_back({last, be_k, be_w});
         q_le.push_back({last, le_k, le_w});
         cur.delete();
      end
   endtask

   task automatic model_reset();
      q_be.delete();
      q_le.delete();
      cur.delete();
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (if_be.in_ready) break;
         n++;
         stall_cnt++;
         if (n > 50) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      model_accept(d, last);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!rst && if_be.out_valid) valid_cycles++;
      if (!rst && if_be.out_valid && out_ready) begin
         hs_cyc.push_back(cyc);
         if (q_be.size() == 0) chk("be_unexpected_word", {if_be.out_last, if_be.out_keep, if_be.out_data}, 64'd0);
         else chk("be_word", {if_be.out_last, if_be.out_keep, if_be.out_data}, q_be.pop_front());
      end
      if (!rst && if_le.out_valid && out_ready) begin
         if (q_le.size() == 0) chk("le_unexpected_word", {if_le.out_last, if_le.out_keep, if_le.out_data}, 64'd0);
         else chk("le_word", {if_le.out_last, if_le.out_keep, if_le.out_data}, q_le.pop_front());
      end
   end

   initial begin
      #3 rst = 1'b1;
      #1;
      chk("rst_out_valid", if_be.out_valid, 0);
      chk("rst_out_data",  if_be.out_data, 0);
      chk("rst_out_keep",  if_be.out_keep, 0);
      chk("rst_out_last",  if_be.out_last, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", if_be.in_ready, 1);

      // Full big/little-endian word with latency check.
      @(posedge clk); #1;
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      @(negedge clk);
      chk("t1_latency_valid", if_be.out_valid, 1);
      chk("t1_be_data", if_be.out_data, 32'h11223344);
      chk("t2_le_data", if_le.out_data, 32'h44332211);

      // Short packet, then the next packet must restart at the first lane.
      @(posedge clk); #1;
      send(8'hAA, 0); send(8'hBB, 1);
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
      send(8'h77, 1);
      repeat (3) @(negedge clk);

      // Streaming: no stalls, one word every 4 cycles, each valid for 1 cycle.
      @(posedge clk); #1;
      hs_cyc.delete();
      valid_cycles = 0;
      stall_cnt = 0;
      for (int i = 1; i <= 12; i++) send(8'(i), 0);
      repeat (3) @(negedge clk);
      chk("t4_stalls", stall_cnt, 0);
      chk("t4_word_count", hs_cyc.size(), 3);
      chk("t4_valid_cycles", valid_cycles, 3);
      if (hs_cyc.size() == 3) begin
         chk("t4_gap01", hs_cyc[1] - hs_cyc[0], 4);
         chk("t4_gap12", hs_cyc[2] - hs_cyc[1], 4);
      end

      // Backpressure, then release with a completing byte pending.
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
      fork
         send(8'h55, 1);
         begin
            repeat (4) begin
               @(negedge clk);
               chk("t5_in_ready_low", if_be.in_ready, 0);
               chk("t5_data_held", if_be.out_data, 32'h01020304);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("t5_swap_valid", if_be.out_valid, 1);
            chk("t5_swap_data", if_be.out_data, 32'h55000000);
         end
      join
      repeat (2) @(negedge clk);

      // Asynchronous reset with a word pending.
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("t6_async_valid", if_be.out_valid, 0);
      chk("t6_async_data", if_be.out_data, 0);
      chk("t6_async_keep", if_le.out_keep, 0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("t6_in_ready", if_be.in_ready, 1);

      // Asynchronous reset after two bytes; the partial word must vanish.
      @(posedge clk); #1;
      send(8'hEE, 0); send(8'hDD, 0);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("t6_partial_valid", if_be.out_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      @(negedge clk);
      chk("t6_after_rst_data", if_be.out_data, 32'h11223344);
      @(posedge clk); #1;
      send(8'h99, 1);
      repeat (4) @(negedge clk);

      chk("drain_be", q_be.size(), 0);
      chk("drain_le", q_le.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=%0d expected=0", 1);
      $fatal(1, "timeout");
   end
endmodule
